// File: rtl/unit_clause_evaluator.sv
// unit_clause_evaluator
//
// Purpose:
//   Decides whether one clause of up to VAR_PER_CLAUSE literals is a unit
//   clause. A clause is unit when exactly one active literal is still
//   unassigned. For a unit clause it reports the implied variable and the
//   value that makes that literal true. The clause sits in the BCP path
//   between clause fetch and the implication queue. All results are
//   registered: one clause per cycle, one cycle of latency, no backpressure.
//
// Ports:
//   clock             rising-edge clock
//   reset_n           asynchronous, active-low reset
//   in_valid          qualifies the clause inputs this cycle
//   unassign          per slot, 1 = the slot's variable is unassigned
//   clause_mask       per slot, 1 = real literal, 0 = padding
//   clause_pole       per slot, 1 = negated literal, 0 = positive literal
//   variable          per slot variable ID, packed [VAR_PER_CLAUSE-1:0][VW-1:0]
//   out_valid         result registers hold an evaluation of a valid input
//   is_unit_clause    the evaluated clause is unit
//   implied_variable  variable ID of the single unassigned active literal
//   new_val           value to assign to implied_variable

module unit_clause_evaluator #(
  parameter int VAR_PER_CLAUSE = 5,
  parameter int NUM_VARIABLE   = 128,
  localparam int VW            = $clog2(NUM_VARIABLE)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                in_valid,
  input  logic [VAR_PER_CLAUSE-1:0]           unassign,
  input  logic [VAR_PER_CLAUSE-1:0]           clause_mask,
  input  logic [VAR_PER_CLAUSE-1:0]           clause_pole,
  input  logic [VAR_PER_CLAUSE-1:0][VW-1:0]   variable,
  output logic                                out_valid,
  output logic                                is_unit_clause,
  output logic [VW-1:0]                       implied_variable,
  output logic                                new_val
);

  logic [VAR_PER_CLAUSE-1:0] cand;
  logic                      seen_one;
  logic                      seen_many;
  logic [VW-1:0]             sel_variable;
  logic                      sel_pole;
  logic                      unit;
  logic [VW-1:0]             core_variable;
  logic                      core_val;

  // Padding slots never count as candidates, whatever their unassign bit says.
  assign cand = unassign & clause_mask;

  // Scan the candidates once, tracking "at least one" and "more than one"
  // instead of a full popcount. The selected slot data is only meaningful
  // when exactly one candidate was seen; otherwise it is discarded below.
  always_comb begin
    seen_one     = 1'b0;
    seen_many    = 1'b0;
    sel_variable = '0;
    sel_pole     = 1'b0;
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      if (cand[i]) begin
        if (seen_one) begin
          seen_many = 1'b1;
        end
        seen_one     = 1'b1;
        sel_variable = variable[i];
        sel_pole     = clause_pole[i];
      end
    end
  end

  // Non-unit clauses drive all-zero results so no stale slot data leaks out.
  // A positive literal is satisfied by 1, a negated literal by 0.
  always_comb begin
    unit          = seen_one & ~seen_many;
    core_variable = '0;
    core_val      = 1'b0;
    if (unit) begin
      core_variable = sel_variable;
      core_val      = ~sel_pole;
    end
  end

  // Result registers. Idle cycles load zeros so the outputs are clean
  // whenever out_valid is low; reset discards any in-flight result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid        <= 1'b0;
      is_unit_clause   <= 1'b0;
      implied_variable <= '0;
      new_val          <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        is_unit_clause   <= unit;
        implied_variable <= core_variable;
        new_val          <= core_val;
      end else begin
        is_unit_clause   <= 1'b0;
        implied_variable <= '0;
        new_val          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_unit_clause_evaluator.sv
// tb_unit_clause_evaluator
//
// Purpose:
//   Directed self-checking bench for unit_clause_evaluator. Each vector is
//   driven on a falling edge and its registered result is checked shortly
//   after the following rising edge, against hand-computed expectations.
//
// Ports: none (top-level bench).

module tb_unit_clause_evaluator;

  localparam int VPC = 5;
  localparam int NV  = 128;
  localparam int VW  = 7;

  logic                    clock;
  logic                    reset_n;
  logic                    in_valid;
  logic [VPC-1:0]          unassign;
  logic [VPC-1:0]          clause_mask;
  logic [VPC-1:0]          clause_pole;
  logic [VPC-1:0][VW-1:0]  variable;
  logic                    out_valid;
  logic                    is_unit_clause;
  logic [VW-1:0]           implied_variable;
  logic                    new_val;

  int check_count;
  int error_count;

  // Slot IDs: [4]=93 [3]=44 [2]=17 [1]=33 [0]=11, all distinct so a wrong
  // slot selection shows up as a wrong implied_variable.
  logic [VPC-1:0][VW-1:0] base_vars;

  unit_clause_evaluator #(
    .VAR_PER_CLAUSE(VPC),
    .NUM_VARIABLE  (NV)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .unassign        (unassign),
    .clause_mask     (clause_mask),
    .clause_pole     (clause_pole),
    .variable        (variable),
    .out_valid       (out_valid),
    .is_unit_clause  (is_unit_clause),
    .implied_variable(implied_variable),
    .new_val         (new_val)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Checks all four outputs against one expected result.
  task automatic checkAll(input string tag, input logic exp_valid,
                          input logic exp_unit, input logic [VW-1:0] exp_var,
                          input logic exp_val);
    checkOutput({tag, ".out_valid"},        {31'd0, out_valid},      {31'd0, exp_valid});
    checkOutput({tag, ".is_unit_clause"},   {31'd0, is_unit_clause}, {31'd0, exp_unit});
    checkOutput({tag, ".implied_variable"}, {25'd0, implied_variable}, {25'd0, exp_var});
    checkOutput({tag, ".new_val"},          {31'd0, new_val},        {31'd0, exp_val});
  endtask

  // Drives one clause on the falling edge, then checks the result one
  // rising edge later.
  task automatic applyStimulus(input string tag, input logic valid,
                               input logic [VPC-1:0] una, input logic [VPC-1:0] mask,
                               input logic [VPC-1:0] pole,
                               input logic exp_unit, input logic [VW-1:0] exp_var,
                               input logic exp_val);
    @(negedge clock);
    in_valid    = valid;
    unassign    = una;
    clause_mask = mask;
    clause_pole = pole;
    variable    = base_vars;
    @(posedge clock);
    #1;
    checkAll(tag, valid, exp_unit, exp_var, exp_val);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    base_vars   = {7'd93, 7'd44, 7'd17, 7'd33, 7'd11};

    // Reset held with busy, random-looking inputs: outputs must stay zero.
    reset_n     = 1'b0;
    in_valid    = 1'b1;
    unassign    = 5'(($urandom() & 32'h1f) | 32'h1);
    clause_mask = 5'b11111;
    clause_pole = 5'($urandom());
    variable    = base_vars;
    repeat (3) @(posedge clock);
    #1;
    checkAll("reset_hold", 1'b0, 1'b0, 7'd0, 1'b0);

    // Release reset with idle inputs: outputs remain zero.
    @(negedge clock);
    in_valid = 1'b0;
    unassign = '0;
    reset_n  = 1'b1;
    @(posedge clock);
    #1;
    checkAll("after_reset_idle", 1'b0, 1'b0, 7'd0, 1'b0);

    // Single candidate in the top slot, positive then negated.
    applyStimulus("top_pos", 1'b1, 5'b10000, 5'b11111, 5'b00000, 1'b1, 7'd93, 1'b1);
    applyStimulus("top_neg", 1'b1, 5'b10000, 5'b11111, 5'b11111, 1'b1, 7'd93, 1'b0);

    // Middle slot, and a second unassigned bit hidden behind a masked slot 0.
    applyStimulus("mid_pos",     1'b1, 5'b00100, 5'b11110, 5'b00000, 1'b1, 7'd17, 1'b1);
    applyStimulus("mid_masked0", 1'b1, 5'b00101, 5'b11110, 5'b00000, 1'b1, 7'd17, 1'b1);

    // Single candidate in slot 0, negated.
    applyStimulus("slot0_neg", 1'b1, 5'b00001, 5'b11111, 5'b00001, 1'b1, 7'd11, 1'b0);

    // Non-unit clauses: two, all, and zero candidates; fully masked clause.
    applyStimulus("two_cand",   1'b1, 5'b10001, 5'b11111, 5'b00000, 1'b0, 7'd0, 1'b0);
    applyStimulus("all_cand",   1'b1, 5'b11111, 5'b11111, 5'b00000, 1'b0, 7'd0, 1'b0);
    applyStimulus("no_cand",    1'b1, 5'b00000, 5'b11111, 5'b00000, 1'b0, 7'd0, 1'b0);
    applyStimulus("all_masked", 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b0, 7'd0, 1'b0);

    // Back-to-back stream with in_valid held high: unit, non-unit, unit.
    applyStimulus("stream0", 1'b1, 5'b01000, 5'b11111, 5'b01000, 1'b1, 7'd44, 1'b0);
    applyStimulus("stream1", 1'b1, 5'b00110, 5'b11111, 5'b00000, 1'b0, 7'd0,  1'b0);
    applyStimulus("stream2", 1'b1, 5'b00010, 5'b11111, 5'b00000, 1'b1, 7'd33, 1'b1);

    // Idle cycle with unit-looking data: in_valid low must zero everything.
    applyStimulus("idle", 1'b0, 5'b00010, 5'b11111, 5'b00000, 1'b0, 7'd0, 1'b0);

    // Mid-stream asynchronous reset discards the in-flight result at once.
    applyStimulus("pre_async", 1'b1, 5'b10000, 5'b11111, 5'b00000, 1'b1, 7'd93, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checkAll("async_reset", 1'b0, 1'b0, 7'd0, 1'b0);
    @(negedge clock);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    checkAll("post_async_idle", 1'b0, 1'b0, 7'd0, 1'b0);
    applyStimulus("post_async_unit", 1'b1, 5'b10000, 5'b11111, 5'b11111, 1'b1, 7'd93, 1'b0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
